// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    // Sequencer operating modes
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } pc_state_t;

    // Byte distance between consecutive instructions
    localparam logic [31:0] PC_STEP = 32'd4;

    // Default exclusive upper bound of fetch addresses (128 instructions)
    localparam logic [31:0] DEFAULT_PC_LIMIT = 32'h0000_0200;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the pipeline and the PC sequencer.
// master drives the hazard/branch inputs, slave is the sequencer itself.
interface pc_sequencer_if;

    logic        stall;
    logic        branch;
    logic        ALU_zero;
    logic [63:0] branch_offset;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        flush;
    logic        halted;
    logic        error;
    logic [31:0] retired_count;

    modport master (
        output stall, branch, ALU_zero, branch_offset,
        input  pc_out, instr_valid, flush, halted, error, retired_count
    );

    modport slave (
        input  stall, branch, ALU_zero, branch_offset,
        output pc_out, instr_valid, flush, halted, error, retired_count
    );

endinterface

// File: rtl/branch_target_check.sv
// Combinational branch target computation and legality check.
// The offset is in halfword units; only its low 31 bits contribute, so the
// target wraps modulo 2^32. A target is legal when it is word aligned and
// strictly below the fetch limit.
module branch_target_check (
    input  logic [31:0] pc,
    input  logic [63:0] offset,
    input  logic [31:0] limit,
    output logic [31:0] target,
    output logic        legal
);

    // Upper offset bits shift out of the 32-bit address entirely
    logic unused_offset_hi;
    assign unused_offset_hi = ^offset[63:31];

    assign target = pc + {offset[30:0], 1'b0};
    assign legal  = (target < limit) && (target[1:0] == 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps the fetch address, redirects on taken
// branches with a fixed-length flush window, and halts at the end of the
// program or on an illegal branch target until the next reset.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] PC_LIMIT     = DEFAULT_PC_LIMIT,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    // Counter starts one below the window length so flush is high exactly
    // FLUSH_CYCLES cycles including the redirect cycle.
    localparam logic [3:0]  FLUSH_INIT   = 4'(FLUSH_CYCLES - 1);
    localparam logic [31:0] LAST_STEP_PC = PC_LIMIT - PC_STEP;

    pc_state_t   state_reg;
    logic [31:0] pc_reg;
    logic        instr_valid_reg;
    logic        flush_reg;
    logic        halted_reg;
    logic        error_reg;
    logic [31:0] retired_reg;
    logic [3:0]  flush_cnt_reg;

    logic [31:0] target;
    logic        target_legal;
    logic        taken;

    assign taken = bus.branch & bus.ALU_zero;

    branch_target_check u_target_check (
        .pc     (pc_reg),
        .offset (bus.branch_offset),
        .limit  (PC_LIMIT),
        .target (target),
        .legal  (target_legal)
    );

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            pc_reg          <= '0;
            instr_valid_reg <= 1'b1;
            flush_reg       <= 1'b0;
            halted_reg      <= 1'b0;
            error_reg       <= 1'b0;
            retired_reg     <= '0;
            flush_cnt_reg   <= '0;
        end else begin
            if (instr_valid_reg) begin
                retired_reg <= retired_reg + 32'd1;
            end
            case (state_reg)
                RUN: begin
                    if (taken) begin
                        instr_valid_reg <= 1'b0;
                        if (target_legal) begin
                            pc_reg        <= target;
                            state_reg     <= FLUSH;
                            flush_reg     <= 1'b1;
                            flush_cnt_reg <= FLUSH_INIT;
                        end else begin
                            state_reg  <= HALT;
                            halted_reg <= 1'b1;
                            error_reg  <= 1'b1;
                        end
                    end else if (bus.stall) begin
                        instr_valid_reg <= 1'b0;
                    end else if (pc_reg < LAST_STEP_PC) begin
                        pc_reg          <= pc_reg + PC_STEP;
                        instr_valid_reg <= 1'b1;
                    end else begin
                        state_reg       <= HALT;
                        halted_reg      <= 1'b1;
                        error_reg       <= 1'b0;
                        instr_valid_reg <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg != 4'd0) begin
                        flush_cnt_reg <= flush_cnt_reg - 4'd1;
                    end else begin
                        state_reg       <= RUN;
                        flush_reg       <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                HALT: begin
                    // Frozen until reset
                end
                default: begin
                    state_reg <= HALT;
                end
            endcase
        end
    end

    assign bus.pc_out        = pc_reg;
    assign bus.instr_valid   = instr_valid_reg;
    assign bus.flush         = flush_reg;
    assign bus.halted        = halted_reg;
    assign bus.error         = error_reg;
    assign bus.retired_count = retired_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each stimulus cycle pushes the
// reference model's expected outputs; a monitor pops and compares after
// every rising edge.
module tb_pc_sequencer;

    localparam logic [31:0] LIMIT = 32'h200;
    localparam int          FLUSH_N = 2;

    typedef struct {
        logic [31:0] pc;
        logic        iv;
        logic        fl;
        logic        hl;
        logic        er;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    pc_sequencer_if bus ();

    pc_sequencer #(
        .PC_LIMIT     (LIMIT),
        .FLUSH_CYCLES (FLUSH_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, expressed in terms of observable behaviour
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_flush_left;   // flush cycles still to be shown
    logic        m_halted;
    logic        m_err;
    logic [31:0] m_cnt;

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endfunction

    function automatic void model_step(logic rst, logic st, logic br, logic z,
                                       logic [63:0] off);
        longint tgt;
        if (rst) begin
            m_pc = 0; m_valid = 1; m_flush_left = 0;
            m_halted = 0; m_err = 0; m_cnt = 0;
            return;
        end
        if (m_valid) m_cnt = m_cnt + 1;
        if (m_halted) begin
            // nothing moves
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) m_valid = 1;
        end else if (br && z) begin
            tgt = (longint'(m_pc) + 2 * (longint'(off) & 64'h7FFF_FFFF)) % 64'h1_0000_0000;
            m_valid = 0;
            if (tgt < longint'(LIMIT) && (tgt % 4) == 0) begin
                m_pc = 32'(tgt);
                m_flush_left = FLUSH_N;
            end else begin
                m_halted = 1; m_err = 1;
            end
        end else if (st) begin
            m_valid = 0;
        end else if (longint'(m_pc) + 4 < longint'(LIMIT)) begin
            m_pc = m_pc + 4;
            m_valid = 1;
        end else begin
            m_halted = 1; m_err = 0; m_valid = 0;
        end
    endfunction

    // Drive one cycle of inputs and record what must appear after the edge
    task automatic step(input logic rst, input logic st, input logic br,
                        input logic z, input logic [63:0] off);
        exp_t e;
        @(negedge clk);
        reset = rst;
        bus.stall = st;
        bus.branch = br;
        bus.ALU_zero = z;
        bus.branch_offset = off;
        model_step(rst, st, br, z, off);
        e.pc = m_pc; e.iv = m_valid; e.fl = (m_flush_left > 0);
        e.hl = m_halted; e.er = m_err; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one scoreboard transaction per rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pc_out",        bus.pc_out,               e.pc);
                cmp("instr_valid",   32'(bus.instr_valid),     32'(e.iv));
                cmp("flush",         32'(bus.flush),           32'(e.fl));
                cmp("halted",        32'(bus.halted),          32'(e.hl));
                cmp("error",         32'(bus.error),           32'(e.er));
                cmp("retired_count", bus.retired_count,        e.cnt);
            end
        end
    end

    initial begin
        logic [63:0] off;
        logic        rst_r, st_r, br_r, z_r;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.branch = 1'b0;
        bus.ALU_zero = 1'b0;
        bus.branch_offset = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 64'd8);
        after_edge();
        cmp("rst_pc", bus.pc_out, 32'h0);
        cmp("rst_valid", 32'(bus.instr_valid), 32'd1);
        cmp("rst_count", bus.retired_count, 32'd0);

        // Free run five cycles
        idle(5);
        after_edge();
        cmp("run5_pc", bus.pc_out, 32'h14);
        cmp("run5_count", bus.retired_count, 32'd5);

        // Taken branch at 0x10, offset 8 halfwords -> 0x20
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 64'd8);
        after_edge();
        cmp("br_pc", bus.pc_out, 32'h20);
        cmp("br_flush", 32'(bus.flush), 32'd1);
        idle(3);
        after_edge();
        cmp("br_next_pc", bus.pc_out, 32'h24);

        // Stall three cycles at 0x8 with a not-taken branch
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'd8);
        after_edge();
        cmp("stall_pc", bus.pc_out, 32'h8);
        cmp("stall_count", bus.retired_count, 32'd3);
        idle(1);

        // Run to the end of the program, then ignore a taken branch
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(128);
        after_edge();
        cmp("end_halted", 32'(bus.halted), 32'd1);
        cmp("end_error", 32'(bus.error), 32'd0);
        cmp("end_pc", bus.pc_out, 32'h1FC);
        step(1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
        after_edge();
        cmp("halt_hold_pc", bus.pc_out, 32'h1FC);

        // Misaligned and out-of-range targets
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 64'd1);
        after_edge();
        cmp("misalign_err", 32'(bus.error), 32'd1);
        cmp("misalign_pc", bus.pc_out, 32'h10);
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 64'h100);
        after_edge();
        cmp("range_err", 32'(bus.error), 32'd1);

        // Reset during the second flush cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 64'd8);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        after_edge();
        cmp("midflush_rst_pc", bus.pc_out, 32'h0);
        cmp("midflush_rst_flush", 32'(bus.flush), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 7) == 0);
            st_r  = ($urandom_range(0, 3) == 0);
            br_r  = ($urandom_range(0, 4) == 0);
            z_r   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: off = 64'(2 * $urandom_range(0, 20));
                6:                off = 64'(2 * $urandom_range(0, 20) + 1);
                7:                off = -64'(2 * $urandom_range(1, 20));
                8:                off = {$urandom, $urandom};
                default:          off = 64'(2 * $urandom_range(0, 200));
            endcase
            step(rst_r, st_r, br_r, z_r, off);
        end

        repeat (3) @(posedge clk);
        #3;
        cmp("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_LIMIT, default 32'h0000_0200, exclusive upper bound of fetch addresses (128 instructions x 4 bytes).
REQ-002 Parameter FLUSH_CYCLES, default 2, cycles of flush after a taken branch; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold request; PC frozen this cycle.
REQ-006 branch  input  1  branch instruction in execute.
REQ-007 ALU_zero  input  1  ALU zero flag; taken = branch & ALU_zero.
REQ-008 branch_offset  input  64  signed immediate, halfword units.
REQ-009 pc_out  output  32  registered fetch address.
REQ-010 instr_valid  output  1  registered; pc_out holds an instruction to execute.
REQ-011 flush  output  1  registered; downstream shall discard in-flight instructions.
REQ-012 halted  output  1  registered; sequencer stopped until reset.
REQ-013 error  output  1  registered; halt caused by an illegal branch target.
REQ-014 retired_count  output  32  registered count of cycles with instr_valid=1; wraps modulo 2^32.

Function
REQ-015 FSM states RUN, FLUSH, HALT; all inputs other than reset are sampled on the rising edge.
REQ-016 Target = pc_out + (branch_offset[30:0] << 1), computed modulo 2^32.
REQ-017 RUN priority, highest first: taken branch > stall > increment > limit halt.
REQ-018 RUN, taken, target < PC_LIMIT and target[1:0]==0: pc_out<=target; next state FLUSH; flush<=1; instr_valid<=0; flush counter<=FLUSH_CYCLES-1.
REQ-019 RUN, taken, target >= PC_LIMIT or target[1:0]!=0: pc_out held; next state HALT; halted<=1; error<=1; instr_valid<=0.
REQ-020 RUN, not taken, stall=1: pc_out held; instr_valid<=0; state stays RUN.
REQ-021 RUN, not taken, no stall, pc_out < PC_LIMIT-4: pc_out<=pc_out+4; instr_valid<=1.
REQ-022 RUN, not taken, no stall, pc_out >= PC_LIMIT-4: pc_out held; next state HALT; halted<=1; error<=0; instr_valid<=0.
REQ-023 branch=1 with ALU_zero=0 is not taken and behaves exactly as REQ-020..022.
REQ-024 FLUSH: stall, branch and ALU_zero are ignored; pc_out held at the target.
REQ-025 FLUSH, counter>0: counter decrements; flush stays 1.
REQ-026 FLUSH, counter==0: next state RUN; flush<=0; instr_valid<=1. flush is therefore high for exactly FLUSH_CYCLES cycles.
REQ-027 HALT: all outputs frozen and all inputs ignored until reset.
REQ-028 retired_count increments on each rising edge at which instr_valid is 1 and reset is 0.

Reset
REQ-029 reset=1 at a rising edge overrides every other condition in every state, including mid-FLUSH and HALT.
REQ-030 Reset values: state RUN, pc_out 0, instr_valid 1, flush 0, halted 0, error 0, retired_count 0, flush counter 0.

Structure
REQ-031 Shared package pc_seq_pkg holds the state enum (RUN, FLUSH, HALT), PC_STEP=4, and the default PC_LIMIT.
REQ-032 Target computation and legality checks live in one combinational sub-module, branch_target_check (inputs pc, offset, limit; outputs target, legal).

Verification (PC_LIMIT=0x200, FLUSH_CYCLES=2)
REQ-033 Release reset, then 5 idle cycles -> pc_out 0x4, 0x8, 0xC, 0x10, 0x14; instr_valid 1 throughout; retired_count 5.
REQ-034 At pc 0x10 drive branch=1, ALU_zero=1, offset=8 -> pc_out 0x20; flush=1 and instr_valid=0 for 2 cycles; then instr_valid=1 at 0x20; next cycle 0x24.
REQ-035 At pc 0x8 drive stall=1 for 3 cycles, plus branch=1 with ALU_zero=0 -> pc_out stays 0x8 and instr_valid=0 for 3 cycles, retired_count frozen; then 0xC.
REQ-036 Free-run to 0x1FC -> next edge halted=1, error=0, pc_out 0x1FC held; a subsequent taken branch has no effect.
REQ-037 At pc 0x10 drive a taken branch with offset=1 (target 0x12) -> halted=1, error=1, pc_out 0x10. Separately, offset=0x100 (target 0x210) -> same halt with error=1.
REQ-038 Assert reset during the second FLUSH cycle -> next edge pc_out 0, flush 0, instr_valid 1, state RUN.
